// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, state
// encoding, datapath mux codes and the bundled control-word type.
package controller_pkg;

    // Opcodes, taken from IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // State encoding, also visible on state_dbg
    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_MEM_ADR = 4'd2;
    localparam logic [3:0] ST_MEM_RD  = 4'd3;
    localparam logic [3:0] ST_MEM_WB  = 4'd4;
    localparam logic [3:0] ST_MEM_WR  = 4'd5;
    localparam logic [3:0] ST_EXEC    = 4'd6;
    localparam logic [3:0] ST_ALU_WB  = 4'd7;
    localparam logic [3:0] ST_BRANCH  = 4'd8;
    localparam logic [3:0] ST_ADDI_EX = 4'd9;
    localparam logic [3:0] ST_ADDI_WB = 4'd10;
    localparam logic [3:0] ST_JUMP    = 4'd11;
    localparam logic [3:0] ST_HALT    = 4'd12;

    typedef enum logic [3:0] {
        S_FETCH   = ST_FETCH,
        S_DECODE  = ST_DECODE,
        S_MEM_ADR = ST_MEM_ADR,
        S_MEM_RD  = ST_MEM_RD,
        S_MEM_WB  = ST_MEM_WB,
        S_MEM_WR  = ST_MEM_WR,
        S_EXEC    = ST_EXEC,
        S_ALU_WB  = ST_ALU_WB,
        S_BRANCH  = ST_BRANCH,
        S_ADDI_EX = ST_ADDI_EX,
        S_ADDI_WB = ST_ADDI_WB,
        S_JUMP    = ST_JUMP,
        S_HALT    = ST_HALT
    } state_t;

    // ALU operation select
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // One cycle's worth of datapath control
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    // States that wait on the memory handshake and can time out
    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle. The controller is the
// master; the datapath side (or a testbench) uses the slave view.
interface multicycle_controller_if;
    import controller_pkg::*;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       halt_req;

    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       halted;
    logic       instr_retired;
    logic       illegal_op;
    logic       bus_err;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, zero, mem_ready, halt_req,
        output pc_write, ir_write, reg_write, mem_read, mem_write,
               iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, pc_src, halted, instr_retired, illegal_op,
               bus_err, state_dbg
    );

    modport slave (
        output opcode, zero, mem_ready, halt_req,
        input  pc_write, ir_write, reg_write, mem_read, mem_write,
               iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, pc_src, halted, instr_retired, illegal_op,
               bus_err, state_dbg
    );

endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Counts cycles spent waiting for mem_ready; expired goes high once the
// count has reached TIMEOUT_CYCLES.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q;

    // Wait counter: clear wins over increment
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples the pre-edge values and simulation matches the hardware.
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM with memory-ready handshake, wait timeout,
// halt request and retire/error status.
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);

    state_t state;
    state_t state_next;
    state_t dec_state;
    state_t boundary;
    ctrl_t  ctrl;

    logic illegal_q;
    logic bus_err_q;
    logic retire;
    logic set_illegal;
    logic mem_state;
    logic expired;
    logic timeout;
    logic timer_clear;
    logic timer_en;

    // A memory state gives up only if the limit is hit and the access
    // still has not completed in that same cycle.
    assign mem_state = is_mem_state(state);
    assign timer_en  = mem_state && !bus.mem_ready;
    assign timeout   = !rst && timer_en && expired;

    // Every state change (and every abort, which may re-enter FETCH from
    // FETCH) restarts the wait count for the next memory state.
    assign timer_clear = (state_next != state) || timeout;

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (expired)
    );

    // Instruction boundary: halt_req decides between FETCH and HALT
    assign boundary = bus.halt_req ? S_HALT : S_FETCH;

    // State register and sticky status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state <= state_next;
            if (set_illegal) illegal_q <= 1'b1;
            if (timeout)     bus_err_q <= 1'b1;
        end
    end

    // Next-state logic, retire pulse and illegal-opcode detection
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_next  = state;
        retire      = 1'b0;
        set_illegal = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (bus.mem_ready) state_next = S_DECODE;
                else if (timeout)  state_next = S_FETCH;
                else if (bus.halt_req) state_next = S_HALT;
            end
            S_DECODE: begin
                unique case (bus.opcode)
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_LW, OP_SW: state_next = S_MEM_ADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        set_illegal = 1'b1;
                        retire      = 1'b1;
                        state_next  = boundary;
                    end
                endcase
            end
            S_MEM_ADR: state_next = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.mem_ready) state_next = S_MEM_WB;
                else if (timeout)  state_next = S_FETCH;
            end
            S_MEM_WR: begin
                if (bus.mem_ready) begin
                    retire     = 1'b1;
                    state_next = boundary;
                end else if (timeout) begin
                    state_next = S_FETCH;
                end
            end
            S_EXEC:    state_next = S_ALU_WB;
            S_ADDI_EX: state_next = S_ADDI_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_ADDI_WB, S_JUMP: begin
                retire     = 1'b1;
                state_next = boundary;
            end
            S_HALT: begin
                if (!bus.halt_req) state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // While in reset the outputs show the FETCH decode
    assign dec_state = rst ? S_FETCH : state;

    // Datapath control decode, then reset and timeout strobe gating
    always_comb begin
        ctrl = '0;
        unique case (dec_state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_ALU;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            S_MEM_WR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_ALUOUT;
                ctrl.pc_write  = bus.zero;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
            S_JUMP: begin
                ctrl.pc_src   = PC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ;
        endcase

        if (rst) begin
            ctrl.pc_write  = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.mem_write = 1'b0;
        end else if (timeout) begin
            ctrl.pc_write  = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
        end
    end

    assign bus.pc_write   = ctrl.pc_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.iord       = ctrl.iord;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.pc_src     = ctrl.pc_src;

    // Status: error flags show in the cycle they are raised, then stick
    assign bus.halted        = !rst && (state == S_HALT);
    assign bus.instr_retired = !rst && retire;
    assign bus.illegal_op    = !rst && (illegal_q || set_illegal);
    assign bus.bus_err       = !rst && (bus_err_q || timeout);
    assign bus.state_dbg     = dec_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller (TIMEOUT_CYCLES = 4), plus
// hand-written sequences for fetch timeout and R-type latency.
module tb_multicycle_controller;

    // Expected state codes
    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                           MW = 4'd5, EX = 4'd6, AWB = 4'd7, BR = 4'd8,
                           AEX = 4'd9, AWB2 = 4'd10, J = 4'd11, H = 4'd12;

    // Mux field pattern: {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src}
    localparam logic [9:0] M_FETCH = 10'b0000010000;
    localparam logic [9:0] M_DEC   = 10'b0000110000;
    localparam logic [9:0] M_IMM   = 10'b0001100000;
    localparam logic [9:0] M_MEM   = 10'b1000000000;
    localparam logic [9:0] M_MWB   = 10'b0010000000;
    localparam logic [9:0] M_EXEC  = 10'b0001001000;
    localparam logic [9:0] M_AWB   = 10'b0100000000;
    localparam logic [9:0] M_BR    = 10'b0001000101;
    localparam logic [9:0] M_JUMP  = 10'b0000000010;
    localparam logic [9:0] M_NONE  = 10'b0000000000;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                           OP_ILL = 6'b111111;

    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op;
        logic       zero;
        logic       rdy;
        logic       halt;
        logic [3:0] st;
        logic [4:0] stb;  // {pc_write, ir_write, reg_write, mem_read, mem_write}
        logic [9:0] mux;
        logic [3:0] flg;  // {halted, instr_retired, illegal_op, bus_err}
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    multicycle_controller_if bus_if ();

    multicycle_controller #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic r, input logic [5:0] op,
                       input logic z, input logic rdy, input logic halt,
                       input logic [3:0] st, input logic [4:0] stb,
                       input logic [9:0] mux, input logic [3:0] flg);
        vec_t v;
        v.name = name; v.rst = r; v.op = op; v.zero = z; v.rdy = rdy; v.halt = halt;
        v.st = st; v.stb = stb; v.mux = mux; v.flg = flg;
        vecs.push_back(v);
    endtask

    function automatic logic [22:0] observed();
        return {bus_if.state_dbg,
                bus_if.pc_write, bus_if.ir_write, bus_if.reg_write,
                bus_if.mem_read, bus_if.mem_write,
                bus_if.iord, bus_if.reg_dst, bus_if.mem_to_reg, bus_if.alu_src_a,
                bus_if.alu_src_b, bus_if.alu_op, bus_if.pc_src,
                bus_if.halted, bus_if.instr_retired, bus_if.illegal_op, bus_if.bus_err};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   found;
        int   retires;
        int   lat;
        logic [4:0] stb_at_abort;

        // name            rst op      z  rdy h   state stb       mux      flags
        add("reset",        1, OP_R,   0, 1, 0,  F,   5'b00010, M_FETCH, 4'b0000);
        add("r_fetch",      0, OP_R,   0, 1, 0,  F,   5'b11010, M_FETCH, 4'b0000);
        add("r_decode",     0, OP_R,   0, 1, 0,  D,   5'b00000, M_DEC,   4'b0000);
        add("r_exec",       0, OP_R,   0, 1, 0,  EX,  5'b00000, M_EXEC,  4'b0000);
        add("r_alu_wb",     0, OP_R,   0, 1, 0,  AWB, 5'b00100, M_AWB,   4'b0100);
        add("lw_fetch",     0, OP_LW,  0, 1, 0,  F,   5'b11010, M_FETCH, 4'b0000);
        add("lw_decode",    0, OP_LW,  0, 1, 0,  D,   5'b00000, M_DEC,   4'b0000);
        add("lw_mem_adr",   0, OP_LW,  0, 1, 0,  MA,  5'b00000, M_IMM,   4'b0000);
        add("lw_rd_wait1",  0, OP_LW,  0, 0, 0,  MR,  5'b00010, M_MEM,   4'b0000);
        add("lw_rd_wait2",  0, OP_LW,  0, 0, 0,  MR,  5'b00010, M_MEM,   4'b0000);
        add("lw_rd_done",   0, OP_LW,  0, 1, 0,  MR,  5'b00010, M_MEM,   4'b0000);
        add("lw_mem_wb",    0, OP_LW,  0, 1, 0,  MWB, 5'b00100, M_MWB,   4'b0100);
        add("beqt_fetch",   0, OP_BEQ, 1, 1, 0,  F,   5'b11010, M_FETCH, 4'b0000);
        add("beqt_decode",  0, OP_BEQ, 1, 1, 0,  D,   5'b00000, M_DEC,   4'b0000);
        add("beqt_branch",  0, OP_BEQ, 1, 1, 0,  BR,  5'b10000, M_BR,    4'b0100);
        add("beqn_fetch",   0, OP_BEQ, 0, 1, 0,  F,   5'b11010, M_FETCH, 4'b0000);
        add("beqn_decode",  0, OP_BEQ, 0, 1, 0,  D,   5'b00000, M_DEC,   4'b0000);
        add("beqn_branch",  0, OP_BEQ, 0, 1, 0,  BR,  5'b00000, M_BR,    4'b0100);
        add("j_fetch",      0, OP_J,   0, 1, 0,  F,   5'b11010, M_FETCH, 4'b0000);
        add("j_decode",     0, OP_J,   0, 1, 0,  D,   5'b00000, M_DEC,   4'b0000);
        add("j_jump",       0, OP_J,   0, 1, 0,  J,   5'b10000, M_JUMP,  4'b0100);
        add("ill_fetch",    0, OP_ILL, 0, 1, 0,  F,   5'b11010, M_FETCH, 4'b0000);
        add("ill_decode",   0, OP_ILL, 0, 1, 0,  D,   5'b00000, M_DEC,   4'b0110);
        add("swe_fetch",    0, OP_SW,  0, 1, 0,  F,   5'b11010, M_FETCH, 4'b0010);
        add("swe_decode",   0, OP_SW,  0, 1, 0,  D,   5'b00000, M_DEC,   4'b0010);
        add("swe_mem_adr",  0, OP_SW,  0, 1, 0,  MA,  5'b00000, M_IMM,   4'b0010);
        add("swe_wait1",    0, OP_SW,  0, 0, 0,  MW,  5'b00001, M_MEM,   4'b0010);
        add("swe_wait2",    0, OP_SW,  0, 0, 0,  MW,  5'b00001, M_MEM,   4'b0010);
        add("swe_wait3",    0, OP_SW,  0, 0, 0,  MW,  5'b00001, M_MEM,   4'b0010);
        add("swe_wait4",    0, OP_SW,  0, 0, 0,  MW,  5'b00001, M_MEM,   4'b0010);
        add("swe_ready_at_limit", 0, OP_SW, 0, 1, 0, MW, 5'b00001, M_MEM, 4'b0110);
        add("swt_fetch",    0, OP_SW,  0, 1, 0,  F,   5'b11010, M_FETCH, 4'b0010);
        add("swt_decode",   0, OP_SW,  0, 1, 0,  D,   5'b00000, M_DEC,   4'b0010);
        add("swt_mem_adr",  0, OP_SW,  0, 1, 0,  MA,  5'b00000, M_IMM,   4'b0010);
        add("swt_wait1",    0, OP_SW,  0, 0, 0,  MW,  5'b00001, M_MEM,   4'b0010);
        add("swt_wait2",    0, OP_SW,  0, 0, 0,  MW,  5'b00001, M_MEM,   4'b0010);
        add("swt_wait3",    0, OP_SW,  0, 0, 0,  MW,  5'b00001, M_MEM,   4'b0010);
        add("swt_wait4",    0, OP_SW,  0, 0, 0,  MW,  5'b00001, M_MEM,   4'b0010);
        add("swt_abort",    0, OP_SW,  0, 0, 0,  MW,  5'b00000, M_MEM,   4'b0011);
        add("addi_fetch",   0, OP_ADDI,0, 1, 1,  F,   5'b11010, M_FETCH, 4'b0011);
        add("addi_decode",  0, OP_ADDI,0, 1, 1,  D,   5'b00000, M_DEC,   4'b0011);
        add("addi_ex",      0, OP_ADDI,0, 1, 1,  AEX, 5'b00000, M_IMM,   4'b0011);
        add("addi_wb",      0, OP_ADDI,0, 1, 1,  AWB2,5'b00100, M_NONE,  4'b0111);
        add("halt_hold",    0, OP_ADDI,0, 1, 1,  H,   5'b00000, M_NONE,  4'b1011);
        add("halt_release", 0, OP_ADDI,0, 1, 0,  H,   5'b00000, M_NONE,  4'b1011);
        add("idle_fetch_halt", 0, OP_J, 0, 0, 1, F,   5'b00010, M_FETCH, 4'b0011);
        add("halt_idle",    0, OP_J,   0, 0, 0,  H,   5'b00000, M_NONE,  4'b1011);
        add("resume_fetch", 0, OP_J,   0, 1, 0,  F,   5'b11010, M_FETCH, 4'b0011);
        add("rst_in_decode",1, OP_J,   0, 1, 0,  F,   5'b00010, M_FETCH, 4'b0000);
        add("after_reset",  0, OP_J,   0, 0, 0,  F,   5'b00010, M_FETCH, 4'b0000);

        bus_if.opcode    = OP_R;
        bus_if.zero      = 1'b0;
        bus_if.mem_ready = 1'b0;
        bus_if.halt_req  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            rst              = vecs[i].rst;
            bus_if.opcode    = vecs[i].op;
            bus_if.zero      = vecs[i].zero;
            bus_if.mem_ready = vecs[i].rdy;
            bus_if.halt_req  = vecs[i].halt;
            #3;
            check(vecs[i].name, {9'd0, observed()},
                  {9'd0, vecs[i].st, vecs[i].stb, vecs[i].mux, vecs[i].flg});
            @(posedge clk);
            #1;
        end

        // Fetch that never completes: aborts after 4 wait cycles, then retries
        rst = 1'b1;
        bus_if.mem_ready = 1'b0;
        bus_if.halt_req  = 1'b0;
        bus_if.opcode    = OP_R;
        @(posedge clk);
        #1;
        rst = 1'b0;
        found = -1;
        retires = 0;
        stb_at_abort = 5'b11111;
        for (int c = 0; c < 20; c++) begin
            #3;
            if (bus_if.instr_retired) retires++;
            if (bus_if.bus_err) begin
                found = c;
                stb_at_abort = {bus_if.pc_write, bus_if.ir_write, bus_if.reg_write,
                                bus_if.mem_read, bus_if.mem_write};
                break;
            end
            @(posedge clk);
            #1;
        end
        check("fetch_timeout_cycle", found, 4);
        check("fetch_timeout_strobes", {27'd0, stb_at_abort}, 32'd0);
        check("fetch_timeout_no_retire", retires, 0);
        @(posedge clk);
        #3;
        check("fetch_retry", {26'd0, bus_if.state_dbg, bus_if.mem_read, bus_if.bus_err},
              {26'd0, F, 1'b1, 1'b1});

        // R-type latency measured from FETCH to the retire pulse
        bus_if.mem_ready = 1'b1;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (bus_if.instr_retired) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #2;
        end
        check("rtype_latency", lat, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle MIPS control FSM; sequences a shared-memory datapath (one memory for instructions and data, one ALU, IR/MDR/A/B/ALUOut registers) over several cycles per instruction.
- Supports R-type, lw, sw, beq, addi, j, identified by the 6-bit opcode from IR[31:26].
- Adds a memory ready handshake with timeout, a halt request, and retire/error status.

Parameters:
- TIMEOUT_CYCLES, 15, maximum wait cycles for mem_ready in a memory state before abort (1..255).
- CNT_W, 8, width of the wait counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the access this cycle
- halt_req  in  1  request to stop at the next instruction boundary
- pc_write, ir_write, reg_write, mem_read, mem_write  out  1  datapath strobes
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- halted  out  1  FSM is in HALT
- instr_retired  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  sticky; undefined opcode seen
- bus_err  out  1  sticky; memory timeout occurred
- state_dbg  out  4  current state encoding

Behaviour:
- States: FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, BRANCH, ADDI_EX, ADDI_WB, JUMP, HALT.
- Reset:
  - State goes to FETCH; wait counter, illegal_op and bus_err go to 0.
  - While rst is high, pc_write, ir_write, reg_write and mem_write are forced to 0.
  - Every other output shows the FETCH decode.
  - instr_retired = 0 and halted = 0.
- Outputs are a combinational decode of state, with mem_ready gating. Any signal not listed for a state is 0.
- FETCH:
  - Outputs: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00.
  - ir_write and pc_write are 1 only when mem_ready is 1.
  - Transition: if mem_ready is 1, go to DECODE; otherwise stay.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 00.
  - Next state by opcode: 000000 → EXEC; 100011 and 101011 → MEM_ADR; 000100 → BRANCH; 001000 → ADDI_EX; 000010 → JUMP.
  - Any other opcode: set illegal_op, pulse instr_retired, go to FETCH.
- MEM_ADR:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - Next: lw → MEM_RD, sw → MEM_WR.
- MEM_RD:
  - Outputs: mem_read = 1, iord = 1.
  - Transition: when mem_ready is 1, go to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0; pulse retired; go to FETCH.
- MEM_WR:
  - Outputs: iord = 1; mem_write = 1, held until mem_ready is 1.
  - Transition: when mem_ready is 1, pulse retired and go to FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10; go to ALU_WB.
- ALU_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0; pulse retired; go to FETCH.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01.
  - pc_write = zero.
  - Pulse retired; go to FETCH.
- ADDI_EX: alu_src_a = 1, alu_src_b = 10, alu_op = 00; go to ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0; pulse retired; go to FETCH.
- JUMP: pc_src = 10, pc_write = 1; pulse retired; go to FETCH.
- Latency with mem_ready tied to 1:
  - R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3.
  - Each mem_ready low cycle adds one cycle.
- Halt:
  - halt_req is sampled only at entry to FETCH, i.e. on the transition out of a retiring state, or while already in FETCH with no access in progress (mem_ready not yet seen).
  - If halt_req is 1 there, go to HALT instead. In HALT all strobes are 0 and halted = 1.
  - HALT returns to FETCH on the first cycle halt_req is 0.
- Timeout:
  - Wait counter clears on entry to FETCH, MEM_RD or MEM_WR and increments each cycle mem_ready is 0.
  - If the counter reaches TIMEOUT_CYCLES with mem_ready still 0:
    - Set bus_err.
    - Suppress all strobes that cycle.
    - Go to FETCH with no retire pulse; the PC is unchanged, so the fetch is retried.
- Simultaneous events:
  - mem_ready = 1 in the same cycle the counter hits the limit: the access completes, and no error is raised.
  - rst overrides everything.
- Sticky flags clear only on rst.

Decomposition:
- Package controller_pkg holds:
  - opcode constants;
  - state encoding (4-bit localparams);
  - alu_op, alu_src_b and pc_src codes.
- One sub-module, mem_wait_timer: counter, clear/enable inputs, timeout output, parameterised by TIMEOUT_CYCLES and CNT_W.

Test Plan:
- Reset, then mem_ready = 1 and opcode 000000 → states FETCH, DECODE, EXEC, ALU_WB; reg_write = 1 with reg_dst = 1 in cycle 4; instr_retired pulses once; PC write in cycle 1.
- lw (100011) with mem_ready low for 2 cycles in MEM_RD → 7 cycles total; reg_write = 1 with mem_to_reg = 1 exactly once; iord = 1 throughout MEM_RD.
- beq (000100) with zero = 1 → pc_write = 1 and pc_src = 01 in cycle 3. With zero = 0 → pc_write = 0 in cycle 3. Both take 3 cycles.
- Opcode 111111 → illegal_op sets in cycle 2; FSM returns to FETCH; no reg_write or mem_write; flag stays 1 until rst.
- sw with mem_ready held 0 and TIMEOUT_CYCLES = 4 → mem_write held 4 cycles; bus_err set; FSM returns to FETCH; no retire pulse.
- halt_req = 1 during an addi → the addi completes (4 cycles), then HALT with halted = 1 and all strobes 0. Drop halt_req → FETCH on the next cycle.
